// File: rtl/line_buffer.sv
// Two-line delay buffer producing a vertical 3-pixel column {row2_old, row1_delayed, row0_new}.
// Optional macro LINE_BUFFER_MEM_CLEAR_EN: reset also zeroes both line memories.
module line_buffer #(
   parameter int PIX_WIDTH   = 16,
   parameter int IMAGE_WIDTH = 640
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   input  logic [PIX_WIDTH-1:0]   pixel_in,
   output logic [3*PIX_WIDTH-1:0] data_col_out
);

   localparam int PTR_W = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMAGE_WIDTH - 1);

   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     ptr_next;
   logic [PIX_WIDTH-1:0] line1 [IMAGE_WIDTH];
   logic [PIX_WIDTH-1:0] line2 [IMAGE_WIDTH];
   logic [PIX_WIDTH-1:0] rd_line1;
   logic [PIX_WIDTH-1:0] rd_line2;
   logic                 advance;

   assign advance  = valid_in & ~rst;
   assign rd_line1 = line1[ptr];
   assign rd_line2 = line2[ptr];

   always_comb begin
      ptr_next = ptr + 1'b1;
      if (ptr == PTR_LAST) begin
         ptr_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         data_col_out <= '0;
      end else if (valid_in) begin
         ptr          <= ptr_next;
         data_col_out <= {rd_line2, rd_line1, pixel_in};
      end
   end

   // Read values above are the pre-write contents, so line2 receives the row that line1 is losing.
`ifdef LINE_BUFFER_MEM_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IMAGE_WIDTH; i++) begin
            line1[i] <= '0;
            line2[i] <= '0;
         end
      end else if (valid_in) begin
         line1[ptr] <= pixel_in;
         line2[ptr] <= rd_line1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (advance) begin
         line1[ptr] <= pixel_in;
         line2[ptr] <= rd_line1;
      end
   end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed self-checking bench for line_buffer (PIX_WIDTH=16, IMAGE_WIDTH=4).
// Unfilled row fields are only checked when LINE_BUFFER_MEM_CLEAR_EN is defined.
module tb_line_buffer;

   localparam int PW = 16;
   localparam int W  = 4;

   logic          clk;
   logic          rst;
   logic          valid_in;
   logic [PW-1:0] pixel_in;
   logic [3*PW-1:0] data_col_out;

   int tests_run = 0;
   int tests_failed = 0;

   int fill_pix [16] = '{1, 2, 3, 4, 11, 12, 13, 14, 21, 22, 23, 24, 31, 32, 33, 34};
   int fill_r1  [16] = '{0, 0, 0, 0, 1, 2, 3, 4, 11, 12, 13, 14, 21, 22, 23, 24};
   int fill_r2  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 11, 12, 13, 14};

   line_buffer #(.PIX_WIDTH(PW), .IMAGE_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .pixel_in     (pixel_in),
      .data_col_out (data_col_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3*PW-1:0] col(input int r2, input int r1, input int r0);
      logic [PW-1:0] a, b, c;
      a = PW'(r2);
      b = PW'(r1);
      c = PW'(r0);
      return {a, b, c};
   endfunction

   // n = number of valid samples since reset; fields not yet written are don't-care without memory clear
   function automatic logic [3*PW-1:0] known_mask(input int n);
      logic [3*PW-1:0] m;
      m = '1;
`ifndef LINE_BUFFER_MEM_CLEAR_EN
      if (n <= W)        m = {{(2*PW){1'b0}}, {PW{1'b1}}};
      else if (n <= 2*W) m = {{PW{1'b0}}, {(2*PW){1'b1}}};
`endif
      return m;
   endfunction

   task automatic step(input logic r, input logic v, input int p);
      rst      = r;
      valid_in = v;
      pixel_in = PW'(p);
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3*PW-1:0] expv, input logic [3*PW-1:0] m);
      tests_run++;
      assert ((data_col_out & m) === (expv & m))
      else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h (mask %h)", tag, data_col_out, expv, m);
      end
   endtask

   initial begin
      logic [3*PW-1:0] held;
      rst = 1'b1;
      valid_in = 1'b0;
      pixel_in = '0;

      // reset with a pixel presented: output stays 0, pixel dropped
      step(1'b1, 1'b1, 7);
      check("reset_cyc0", '0, '1);
      step(1'b1, 1'b1, 7);
      check("reset_cyc1", '0, '1);

      // fill sequence straight after reset
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, fill_pix[i]);
         check($sformatf("fill_%0d", fill_pix[i]),
               col(fill_r2[i], fill_r1[i], fill_pix[i]), known_mask(i + 1));
      end

      // idle cycle holds output
      step(1'b0, 1'b0, 99);
      check("idle_hold", col(14, 24, 34), '1);

      // fill with 3-cycle stalls after every second pixel
      step(1'b1, 1'b0, 0);
      check("stall_reset", '0, '1);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, fill_pix[i]);
         check($sformatf("stall_fill_%0d", fill_pix[i]),
               col(fill_r2[i], fill_r1[i], fill_pix[i]), known_mask(i + 1));
         if (i % 2 == 1) begin
            held = col(fill_r2[i], fill_r1[i], fill_pix[i]);
            for (int s = 0; s < 3; s++) begin
               step(1'b0, 1'b0, 555 + s);
               check($sformatf("stall_hold_%0d_%0d", fill_pix[i], s), held, known_mask(i + 1));
            end
         end
      end

      // reset mid-stream after pixel 13, then restream 1..4
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, fill_pix[i]);
      end
      check("mid_before_rst", col(0, 3, 13), known_mask(7));
      step(1'b1, 1'b1, 77);
      check("mid_rst", '0, '1);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0, 1'b1, k);
         check($sformatf("mid_restream_%0d", k), col(0, 0, k), known_mask(k));
      end

      // wrap continuity over 20 pixels
      step(1'b1, 1'b0, 0);
      for (int n = 1; n <= 20; n++) begin
         step(1'b0, 1'b1, n);
         check($sformatf("wrap_%0d", n),
               col((n > 8) ? n - 8 : 0, (n > 4) ? n - 4 : 0, n), known_mask(n));
      end

      // full-width pass-through of extreme pixel values
      step(1'b0, 1'b1, 16'hFFFF);
      check("wrap_ffff", col(13, 17, 16'hFFFF), '1);
      step(1'b0, 1'b1, 16'h8001);
      check("wrap_8001", col(14, 18, 16'h8001), '1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
